branch_tag_manager: RTL and testbench

Allocates and recycles the in-flight branch tags (`branch_id` + `color_bit`) that decode attaches to every branch/jump and that execute returns with each branch result. It keeps tags in program order in a circular buffer, releases them in order once resolved, squashes all younger tags on a misprediction, and holds allocation off for a fixed recovery window. It sits beside the hazard controller: `full` feeds the decode-side stall, and `flush_*` drives younger-instruction squash in rename/issue.

---
 rtl/branch_tag_manager.sv | 169 ++++++++++++++++
 tb/tb_branch_tag_manager.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_tag_manager.sv
// In-flight branch tag allocator: tags are kept in program order in a circular buffer.
// Resolved tags retire in order. A mispredict squashes all younger tags and blocks allocation for a while.
module branch_tag_manager #(
  parameter int NUM_TAGS        = 4,
  parameter int TAG_W           = $clog2(NUM_TAGS),
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_grant,
  output logic [TAG_W-1:0]    alloc_id,
  output logic                alloc_color,
  input  logic                resolve_valid,
  input  logic [TAG_W-1:0]    resolve_id,
  input  logic                resolve_color,
  input  logic                resolve_miss,
  output logic                full,
  output logic                recovering,
  output logic                flush_valid,
  output logic [TAG_W-1:0]    flush_id,
  output logic                flush_color,
  output logic [NUM_TAGS-1:0] active_mask,
  output logic [TAG_W:0]      count
);

  localparam int PTR_W = TAG_W + 1;
  localparam int CNT_W = $clog2(RECOVERY_CYCLES + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(RECOVERY_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0]    rec_cnt_reg, rec_cnt_next;
  logic [PTR_W-1:0]    head_reg, tail_reg;
  logic [NUM_TAGS-1:0] valid_reg, resolved_reg, color_reg;
  logic                flush_valid_reg, flush_color_reg;
  logic [TAG_W-1:0]    flush_id_reg;

  logic [TAG_W-1:0]    head_idx, tail_idx;
  logic [PTR_W-1:0]    miss_ptr, tail_dist;
  logic                resolve_match, mispredict, release_head;
  logic [NUM_TAGS-1:0] younger;

  assign head_idx = head_reg[TAG_W-1:0];
  assign tail_idx = tail_reg[TAG_W-1:0];

  // A resolve only counts if it names a live tag of the current generation.
  assign resolve_match = resolve_valid && valid_reg[resolve_id]
                         && (color_reg[resolve_id] == resolve_color);
  assign mispredict    = resolve_match && resolve_miss;
  assign release_head  = valid_reg[head_idx] && resolved_reg[head_idx];

  assign count       = tail_reg - head_reg;
  assign full        = (count == PTR_W'(NUM_TAGS));
  assign alloc_grant = alloc_req && !full && (state_reg == IDLE) && !mispredict;
  assign alloc_id    = tail_idx;
  assign alloc_color = tail_reg[TAG_W];

  assign miss_ptr  = {resolve_color, resolve_id};
  assign tail_dist = tail_reg - miss_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_slot
      localparam logic [TAG_W-1:0] SLOT = TAG_W'(gi);
      logic [TAG_W-1:0] slot_dist;
      logic             alloc_hit, release_hit, resolve_hit;

      // Slot lies strictly after the mispredicted tag and before the old tail.
      assign slot_dist   = SLOT - resolve_id;
      assign younger[gi] = (slot_dist != '0) && ({1'b0, slot_dist} < tail_dist);
      assign alloc_hit   = alloc_grant && (tail_idx == SLOT);
      assign release_hit = release_head && (head_idx == SLOT);
      assign resolve_hit = resolve_match && (resolve_id == SLOT);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi]    <= 1'b0;
          resolved_reg[gi] <= 1'b0;
          color_reg[gi]    <= 1'b0;
        end else begin
          if (alloc_hit) begin
            valid_reg[gi]    <= 1'b1;
            resolved_reg[gi] <= 1'b0;
            color_reg[gi]    <= tail_reg[TAG_W];
          end else begin
            if (release_hit || (mispredict && younger[gi]))
              valid_reg[gi] <= 1'b0;
            if (resolve_hit)
              resolved_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (mispredict)
        tail_reg <= miss_ptr + PTR_ONE;
      else if (alloc_grant)
        tail_reg <= tail_reg + PTR_ONE;
      if (release_head)
        head_reg <= head_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_valid_reg <= 1'b0;
      flush_id_reg    <= '0;
      flush_color_reg <= 1'b0;
    end else begin
      flush_valid_reg <= mispredict;
      if (mispredict) begin
        flush_id_reg    <= resolve_id;
        flush_color_reg <= resolve_color;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      rec_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rec_cnt_reg <= rec_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rec_cnt_next = rec_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mispredict) begin
          state_next   = RECOVER;
          rec_cnt_next = RELOAD;
        end
      end
      RECOVER: begin
        if (mispredict)
          rec_cnt_next = RELOAD;
        else if (rec_cnt_reg == '0)
          state_next = IDLE;
        else
          rec_cnt_next = rec_cnt_reg - CNT_ONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign recovering  = (state_reg == RECOVER);
  assign flush_valid = flush_valid_reg;
  assign flush_id    = flush_id_reg;
  assign flush_color = flush_color_reg;
  assign active_mask = valid_reg;

endmodule

// File: tb/tb_branch_tag_manager.sv
// Directed bench for branch_tag_manager: expected grants and flushes go into queues,
// and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_branch_tag_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_grant;
  logic [1:0] alloc_id;
  logic       alloc_color;
  logic       resolve_valid = 1'b0;
  logic [1:0] resolve_id = '0;
  logic       resolve_color = 1'b0;
  logic       resolve_miss = 1'b0;
  logic       full;
  logic       recovering;
  logic       flush_valid;
  logic [1:0] flush_id;
  logic       flush_color;
  logic [3:0] active_mask;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;
  logic [2:0] grant_q[$];
  logic [2:0] flush_q[$];

  branch_tag_manager #(.NUM_TAGS(4), .RECOVERY_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_id(alloc_id), .alloc_color(alloc_color),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_color(resolve_color),
    .resolve_miss(resolve_miss), .full(full), .recovering(recovering),
    .flush_valid(flush_valid), .flush_id(flush_id), .flush_color(flush_color),
    .active_mask(active_mask), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ar, input logic rv, input logic [1:0] rid,
                     input logic rc, input logic rm);
    alloc_req     = ar;
    resolve_valid = rv;
    resolve_id    = rid;
    resolve_color = rc;
    resolve_miss  = rm;
  endtask

  task automatic state_chk(input string tag, input logic [2:0] c, input logic [3:0] m);
    chk({tag, "_count"}, count, c);
    chk({tag, "_mask"}, active_mask, m);
  endtask

  // Monitor: every grant and every flush pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (alloc_grant) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got id=%0d color=%0d required none", alloc_id, alloc_color);
        end else begin
          logic [2:0] e;
          e = grant_q.pop_front();
          if ({alloc_id, alloc_color} !== e) begin
            errors++;
            $display("FAIL grant: got id=%0d color=%0d required id=%0d color=%0d",
                     alloc_id, alloc_color, e[2:1], e[0]);
          end else begin
            $display("grant id=%0d color=%0d", alloc_id, alloc_color);
          end
        end
      end
      if (flush_valid) begin
        checks++;
        if (flush_q.size() == 0) begin
          errors++;
          $display("FAIL flush_unexpected: got id=%0d color=%0d required none", flush_id, flush_color);
        end else begin
          logic [2:0] e;
          e = flush_q.pop_front();
          if ({flush_id, flush_color} !== e) begin
            errors++;
            $display("FAIL flush: got id=%0d color=%0d required id=%0d color=%0d",
                     flush_id, flush_color, e[2:1], e[0]);
          end else begin
            $display("flush id=%0d color=%0d", flush_id, flush_color);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_mask", active_mask, 0);
    chk("rst_recovering", recovering, 0);
    chk("rst_flush_valid", flush_valid, 0);
    cyc();
    rst = 1'b0;

    // Fill the buffer: tags 0..3 color 0
    for (int i = 0; i < 4; i++) begin
      logic [1:0] id;
      id = 2'(i);
      grant_q.push_back({id, 1'b0});
      drv(1, 0, 0, 0, 0);
      cyc();
    end
    state_chk("filled", 4, 4'hF);
    chk("filled_full", full, 1);
    drv(1, 0, 0, 0, 0);
    #1;
    chk("grant_when_full", alloc_grant, 0);
    cyc();

    // Out-of-order correct resolves 2,1,0 then in-order release
    drv(0, 1, 2, 0, 0); cyc(); chk("res2_count", count, 4);
    drv(0, 1, 1, 0, 0); cyc(); chk("res1_count", count, 4);
    drv(0, 1, 0, 0, 0); cyc(); state_chk("res0", 4, 4'hF);
    drv(0, 0, 0, 0, 0);
    cyc(); state_chk("rel0", 3, 4'hE);
    cyc(); state_chk("rel1", 2, 4'hC);
    cyc(); state_chk("rel2", 1, 4'h8);
    grant_q.push_back({2'd0, 1'b1});
    drv(1, 0, 0, 0, 0);
    cyc(); state_chk("wrap_alloc", 2, 4'h9);
    drv(0, 0, 0, 0, 0);

    // Fresh start for the mispredict scenario
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] id;
      id = 2'(i);
      grant_q.push_back({id, 1'b0});
      drv(1, 0, 0, 0, 0);
      cyc();
    end
    state_chk("refill", 4, 4'hF);

    // Mispredict on (1,c0)
    flush_q.push_back({2'd1, 1'b0});
    drv(0, 1, 1, 0, 1);
    cyc();
    state_chk("miss1", 2, 4'h3);
    chk("miss1_flush_valid", flush_valid, 1);
    chk("miss1_flush_id", flush_id, 1);
    chk("miss1_recovering", recovering, 1);
    // Stale resolve of squashed (2,c0) with miss, plus a blocked alloc
    drv(1, 1, 2, 0, 1);
    #1;
    chk("rec1_grant", alloc_grant, 0);
    cyc();
    state_chk("stale", 2, 4'h3);
    chk("stale_flush_valid", flush_valid, 0);
    chk("rec2_recovering", recovering, 1);
    drv(1, 0, 0, 0, 0);
    #1;
    chk("rec2_grant", alloc_grant, 0);
    cyc();
    chk("rec_done", recovering, 0);
    grant_q.push_back({2'd2, 1'b0});
    cyc();
    state_chk("post_rec_alloc", 3, 4'h7);

    // Wrong-color resolve on a live slot is ignored
    drv(0, 1, 0, 1, 1);
    cyc();
    state_chk("wrong_color", 3, 4'h7);
    chk("wrong_color_flush", flush_valid, 0);
    chk("wrong_color_recovering", recovering, 0);

    // Resolve head, then mispredict + head release + alloc request together
    drv(0, 1, 0, 0, 0);
    cyc();
    chk("head_res_count", count, 3);
    flush_q.push_back({2'd2, 1'b0});
    drv(1, 1, 2, 0, 1);
    #1;
    chk("miss_alloc_grant", alloc_grant, 0);
    cyc();
    state_chk("miss_release", 2, 4'h6);
    chk("miss2_flush_valid", flush_valid, 1);
    drv(0, 0, 0, 0, 0);
    cyc(); state_chk("drain1", 1, 4'h4);
    cyc(); state_chk("drain2", 0, 4'h0);
    chk("drain2_recovering", recovering, 0);

    // Full buffer across the wrap, then same-cycle alloc + release
    grant_q.push_back({2'd3, 1'b0});
    grant_q.push_back({2'd0, 1'b1});
    grant_q.push_back({2'd1, 1'b1});
    grant_q.push_back({2'd2, 1'b1});
    drv(1, 0, 0, 0, 0);
    repeat (4) cyc();
    state_chk("wrap_full", 4, 4'hF);
    chk("wrap_full_full", full, 1);
    drv(0, 1, 3, 0, 0);
    cyc();
    drv(1, 0, 0, 0, 0);
    #1;
    chk("alloc_release_grant", alloc_grant, 0);
    cyc();
    chk("alloc_release_count", count, 3);
    chk("alloc_release_full", full, 0);
    grant_q.push_back({2'd3, 1'b1});
    cyc();
    state_chk("refull", 4, 4'hF);
    chk("refull_full", full, 1);

    // Mispredict (2,c1) leaves 3 tags, then async reset mid-recovery
    flush_q.push_back({2'd2, 1'b1});
    drv(0, 1, 2, 1, 1);
    cyc();
    state_chk("pre_reset", 3, 4'h7);
    chk("pre_reset_recovering", recovering, 1);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_full", full, 0);
    chk("arst_mask", active_mask, 0);
    chk("arst_recovering", recovering, 0);
    chk("arst_flush_valid", flush_valid, 0);
    chk("arst_flush_id", flush_id, 0);
    chk("arst_flush_color", flush_color, 0);
    chk("arst_alloc_id", alloc_id, 0);
    chk("arst_alloc_color", alloc_color, 0);
    chk("arst_alloc_grant", alloc_grant, 0);
    cyc();

    chk("grant_queue_empty", grant_q.size(), 0);
    chk("flush_queue_empty", flush_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
